// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module  : rv32i_pkg
// Brief   : RV32I load/store funct3 encodings and LSU state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module  : lsu_align
// Brief   : Combinational lane steering, load extension and access checks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] shifted;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign shifted = rdata_word >> {addr_lo, 3'b000};

  always_comb begin
    load_data  = 32'h0;
    byte_en    = 4'b0000;
    store_data = 32'h0;
    misalign   = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        load_data  = {{24{shifted[7]}}, shifted[7:0]};
        byte_en    = 4'b0001 << addr_lo;
        store_data = {4{wdata[7:0]}};
      end
      F3_BU: begin
        load_data = {24'h0, shifted[7:0]};
        illegal   = we;
      end
      F3_H: begin
        load_data  = {{16{shifted[15]}}, shifted[15:0]};
        byte_en    = 4'b0011 << addr_lo;
        store_data = {2{wdata[15:0]}};
        misalign   = addr_lo[0];
      end
      F3_HU: begin
        load_data = {16'h0, shifted[15:0]};
        misalign  = addr_lo[0];
        illegal   = we;
      end
      F3_W: begin
        load_data  = rdata_word;
        byte_en    = 4'b1111;
        store_data = wdata;
        misalign   = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_dmem.sv
// ============================================================================
// Module  : lsu_dmem
// Brief   : RV32I load/store unit with word-organised data memory,
//           configurable latency and valid/ready handshakes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_dmem
  import rv32i_pkg::*;
#(
  parameter int    DEPTH_WORDS = 64,
  parameter int    ACC_LATENCY = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;

  lsu_state_t state, state_next;
  logic       access;

  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;

  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0] rdata_word;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic [3:0]  byte_en;
  logic        misalign;
  logic        illegal;
  logic        range_err;
  logic        err;

  assign idx        = addr_q[AW+1:2];
  assign range_err  = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
  assign rdata_word = range_err ? 32'h0 : mem[idx];
  assign err        = misalign | illegal | range_err;

  lsu_align u_align (
    .funct3     (f3_q),
    .we         (we_q),
    .addr_lo    (addr_q[1:0]),
    .rdata_word (rdata_word),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .byte_en    (byte_en),
    .store_data (store_data),
    .misalign   (misalign),
    .illegal    (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    access     = 1'b0;
    case (state)
      IDLE: if (req_valid) state_next = BUSY;
      BUSY: begin
        if (cnt == '0) begin
          state_next = RESP;
          access     = 1'b1;
        end
      end
      RESP: if (rsp_valid && rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
    end else begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= CNT_W'(ACC_LATENCY - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access) begin
        rsp_err   <= err;
        rsp_rdata <= (err || we_q) ? 32'h0 : load_data;
      end
    end
  end

  // Storage is not reset; writes are gated by state, which is.
  always_ff @(posedge clk) begin
    if (access && we_q && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

endmodule

`default_nettype wire
